// File: rtl/enemy_vector_draw.sv
// enemy_vector_draw: turns each spawned enemy into a stream of DAC samples.
// Once per frame it walks the shape ROM point list of every live enemy in
// index order (1, 2, 3). Each point is offset by the enemy position and
// saturated to the DAC range.
//
// Sample handshake: a sample is offered while sample_valid=1. x_out, y_out
// and beam_on are held stable until the cycle where sample_valid and
// sample_ready are both 1. That cycle is the transfer. sample_valid drops on
// the following cycle unless another sample is already registered.
module enemy_vector_draw #(
  parameter int DAC_WIDTH    = 8,
  parameter int ADDRESSWIDTH = 16,
  parameter int Y_ENEMY1     = 200,
  parameter int Y_ENEMY2     = 150,
  parameter int Y_ENEMY3     = 100,
  parameter int MAX_POINTS   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_start,
  input  logic                      spawn_enemy1,
  input  logic                      spawn_enemy2,
  input  logic                      spawn_enemy3,
  input  logic [DAC_WIDTH-1:0]      xenemy1,
  input  logic [DAC_WIDTH-1:0]      xenemy2,
  input  logic [DAC_WIDTH-1:0]      xenemy3,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy1,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy2,
  input  logic [ADDRESSWIDTH-1:0]   adr_enemy3,
  output logic [ADDRESSWIDTH-1:0]   rom_adr,
  input  logic [2*DAC_WIDTH+1:0]    rom_data,
  output logic [DAC_WIDTH-1:0]      x_out,
  output logic [DAC_WIDTH-1:0]      y_out,
  output logic                      beam_on,
  output logic                      sample_valid,
  input  logic                      sample_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic [2:0]                dbg_state
);

  localparam int DW = DAC_WIDTH;
  localparam int AW = ADDRESSWIDTH;
  localparam int PW = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;

  localparam logic [DW-1:0] YL1      = DW'(Y_ENEMY1);
  localparam logic [DW-1:0] YL2      = DW'(Y_ENEMY2);
  localparam logic [DW-1:0] YL3      = DW'(Y_ENEMY3);
  localparam logic [PW-1:0] CNT_LAST = PW'(MAX_POINTS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_FETCH  = 3'd2,
    S_WAIT   = 3'd3,
    S_EMIT   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [2:0]    spawn_q, spawn_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] x_lat_q, x_lat_d;
  logic [DW-1:0] y_lat_q, y_lat_d;
  logic [AW-1:0] base_q, base_d;
  logic          last_q, last_d;
  logic [AW-1:0] rom_adr_q, rom_adr_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic          beam_q, beam_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // ROM word fields
  logic          rom_last;
  logic          rom_beam;
  logic [DW-1:0] rom_dx;
  logic [DW-1:0] rom_dy;

  assign rom_last = rom_data[2*DW+1];
  assign rom_beam = rom_data[2*DW];
  assign rom_dx   = rom_data[2*DW-1:DW];
  assign rom_dy   = rom_data[DW-1:0];

  // Offset the latched position by the ROM delta, clamping at full scale
  logic [DW:0]   sum_x, sum_y;
  logic [DW-1:0] x_sat, y_sat;

  assign sum_x = {1'b0, x_lat_q} + {1'b0, rom_dx};
  assign sum_y = {1'b0, y_lat_q} + {1'b0, rom_dy};
  assign x_sat = sum_x[DW] ? {DW{1'b1}} : sum_x[DW-1:0];
  assign y_sat = sum_y[DW] ? {DW{1'b1}} : sum_y[DW-1:0];

  // The shape ends on its last-point flag or when the point limit is reached
  logic shape_end;
  assign shape_end = last_q || (cnt_q == CNT_LAST);

  logic [PW-1:0] cnt_next;
  assign cnt_next = cnt_q + PW'(1);

  logic accept;
  assign accept = valid_q && sample_ready;

  // Pick the lowest live enemy at or after the current index
  logic          found;
  logic [2:0]    found_idx;
  logic [DW-1:0] sel_x;
  logic [DW-1:0] sel_y;
  logic [AW-1:0] sel_adr;

  // Enemy selector: priority search over the spawn snapshot
  always_comb begin
    found     = 1'b0;
    found_idx = 3'd0;
    sel_x     = xenemy1;
    sel_y     = YL1;
    sel_adr   = adr_enemy1;
    if ((idx_q <= 3'd1) && spawn_q[0]) begin
      found     = 1'b1;
      found_idx = 3'd1;
    end else if ((idx_q <= 3'd2) && spawn_q[1]) begin
      found     = 1'b1;
      found_idx = 3'd2;
      sel_x     = xenemy2;
      sel_y     = YL2;
      sel_adr   = adr_enemy2;
    end else if ((idx_q <= 3'd3) && spawn_q[2]) begin
      found     = 1'b1;
      found_idx = 3'd3;
      sel_x     = xenemy3;
      sel_y     = YL3;
      sel_adr   = adr_enemy3;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_SELECT;
      S_SELECT: state_d = found ? S_FETCH : S_IDLE;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT:   state_d = S_EMIT;
      S_EMIT:   if (accept) state_d = shape_end ? S_SELECT : S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values, per state
  always_comb begin
    spawn_d   = spawn_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    x_lat_d   = x_lat_q;
    y_lat_d   = y_lat_q;
    base_d    = base_q;
    last_d    = last_q;
    rom_adr_d = rom_adr_q;
    x_d       = x_q;
    y_d       = y_q;
    beam_d    = beam_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          spawn_d = {spawn_enemy3, spawn_enemy2, spawn_enemy1};
          busy_d  = 1'b1;
          idx_d   = 3'd1;
        end
      end
      S_SELECT: begin
        if (found) begin
          x_lat_d   = sel_x;
          y_lat_d   = sel_y;
          base_d    = sel_adr;
          idx_d     = found_idx;
          cnt_d     = '0;
          rom_adr_d = sel_adr;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      S_WAIT: begin
        x_d     = x_sat;
        y_d     = y_sat;
        beam_d  = rom_beam;
        last_d  = rom_last;
        valid_d = 1'b1;
      end
      S_EMIT: begin
        if (accept) begin
          valid_d = 1'b0;
          if (shape_end) begin
            idx_d = idx_q + 3'd1;
          end else begin
            cnt_d     = cnt_next;
            rom_adr_d = base_q + AW'(cnt_next);
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spawn_q   <= '0;
      idx_q     <= 3'd1;
      cnt_q     <= '0;
      x_lat_q   <= '0;
      y_lat_q   <= '0;
      base_q    <= '0;
      last_q    <= 1'b0;
      rom_adr_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      beam_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      spawn_q   <= spawn_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      x_lat_q   <= x_lat_d;
      y_lat_q   <= y_lat_d;
      base_q    <= base_d;
      last_q    <= last_d;
      rom_adr_q <= rom_adr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      beam_q    <= beam_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rom_adr      = rom_adr_q;
  assign x_out        = x_q;
  assign y_out        = y_q;
  assign beam_on      = beam_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/enemy_vector_draw.md
Name: enemy_vector_draw

Overview:
- Consumes the per-enemy outputs of the game logic (spawn flag, x position, shape ROM base address) and turns each spawned enemy into a stream of DAC (x, y, beam) samples.
- Walks each enemy's shape ROM point list and offsets every point by that enemy's position, saturating at the DAC range.
- Hands samples to the DAC output mux over a valid/ready handshake.
- Sits between game_logic_top and the DAC driver; runs once per display frame on a frame_start pulse.

Parameters:
- DAC_WIDTH, 8, width of x/y coordinates and ROM offsets.
- ADDRESSWIDTH, 16, shape ROM address width.
- Y_ENEMY1, 200, fixed y lane of enemy 1.
- Y_ENEMY2, 150, fixed y lane of enemy 2.
- Y_ENEMY3, 100, fixed y lane of enemy 3.
- MAX_POINTS, 64, per-shape point limit; guards against a missing end flag.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse that starts drawing a frame
- spawn_enemy1 / spawn_enemy2 / spawn_enemy3  in  1 each  enemy n is alive and must be drawn
- xenemy1 / xenemy2 / xenemy3  in  DAC_WIDTH each  enemy n x position
- adr_enemy1 / adr_enemy2 / adr_enemy3  in  ADDRESSWIDTH each  enemy n shape ROM base address
- rom_adr  out  ADDRESSWIDTH  shape ROM read address
- rom_data  in  2*DAC_WIDTH+2  ROM word, valid 1 cycle after rom_adr; bit[2DW+1]=last point, bit[2DW]=beam on, [2DW-1:DW]=dx, [DW-1:0]=dy (unsigned)
- x_out  out  DAC_WIDTH  sample x
- y_out  out  DAC_WIDTH  sample y
- beam_on  out  1  sample beam enable
- sample_valid  out  1  sample held on x_out/y_out/beam_on
- sample_ready  in  1  DAC mux accepts the sample
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the frame has finished

Behaviour:
- Reset (async, rst_n=0): state IDLE; rom_adr=0, x_out=0, y_out=0, beam_on=0, sample_valid=0, busy=0, frame_done=0; enemy index=1, point counter=0.
- FSM states: IDLE, SELECT, FETCH, WAIT, EMIT.
- IDLE: when frame_start=1, latch snapshots of spawn_1..3 into registers, set busy=1, set index=1, go to SELECT.
- SELECT: find the lowest index i ≥ current index with the latched spawn_i=1.
  - If found: latch xenemy_i, adr_enemy_i and Y_ENEMYi; set point counter=0; go to FETCH.
  - If none: pulse frame_done for 1 cycle, set busy=0, go to IDLE.
- FETCH: drive rom_adr = latched base + point counter (mod 2^ADDRESSWIDTH); go to WAIT.
- WAIT: register the result on rom_data.
  - x_out = min(x_lat + dx, 2^DW−1).
  - y_out = min(y_lat + dy, 2^DW−1).
  - beam_on = rom beam bit.
  - Set sample_valid=1; go to EMIT.
- EMIT: hold x_out, y_out, beam_on and sample_valid stable until sample_ready=1. On acceptance (valid&ready in the same cycle), sample_valid drops the next cycle unless a new sample follows.
  - If the last bit is set, or point counter = MAX_POINTS−1: advance index past i and go to SELECT.
  - Otherwise: increment point counter and go to FETCH.
- Latency:
  - frame_start at cycle t → SELECT at t+1, first FETCH at t+2, first sample_valid at t+4.
  - Each further point takes 3 cycles after acceptance when sample_ready is held high.
- Snapshot rule: game logic inputs changing mid-shape do not affect the shape currently being drawn. x and adr are sampled per enemy in SELECT. Spawn flags are sampled once, at frame_start.
- frame_start while busy=1 is ignored.
- Frame with no spawned enemies: frame_done pulses at t+2, with sample_valid never asserted.
- Saturation applies to x and y independently; there is no wrap-around.
- Reset mid-frame: all outputs return to their reset values immediately; no frame_done is issued.

Test Plan:
- Reset, then frame_start with spawn=3'b000 → no sample_valid; frame_done at t+2; busy is high for exactly 1 cycle (t+1).
- spawn1 only, xenemy1=10, adr=0x0100, ROM points (5,3,beam1),(7,0,beam0,last), sample_ready=1 → samples (15,203,1),(17,200,0); rom_adr 0x0100 then 0x0101; then frame_done.
- All three spawned, 1-point shapes → samples emitted in order enemy1, enemy2, enemy3 with y = 200, 150, 100; a single frame_done.
- xenemy1=250, dx=20, dy=80 → x_out=255, y_out=255 (saturated).
- sample_ready held low 10 cycles → sample_valid and its data are stable for 10 cycles; exactly one sample is accepted on release; a second frame_start during this time is ignored.
- ROM word with no last bit → shape terminates after MAX_POINTS=64 samples; rst_n pulsed low mid-shape → sample_valid=0 and busy=0 immediately.
